atm_controller: RTL and testbench
=================================

ATM_CONTROLLER -- requirements
Module: atm_controller

Interface
REQ-001 The block SHALL have parameter NUM_ACCOUNTS, default 8, meaning the number of account slots (2..64).
REQ-002 The block SHALL have parameter BAL_W, default 16, meaning the balance and amount width in bits.
REQ-003 The block SHALL have parameter PIN_W, default 16, meaning the PIN width in bits.
REQ-004 The block SHALL have parameter MAX_TRIES, default 3, meaning consecutive wrong PINs before an account locks.
REQ-005 The block SHALL have parameter SESSION_LIMIT, default 1000, meaning the maximum total withdrawn per card session.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high, with ports clk and rst.
REQ-007 Ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- card_inserted  in  1  level, card present
- card_id  in  AW=$clog2(NUM_ACCOUNTS)  account index, sampled on insertion
- pin_valid  in  1  PIN strobe
- pin_in  in  PIN_W  entered PIN
- op_valid  in  1  operation strobe
- op_sel  in  2  01 withdraw, 10 deposit, 11 balance, 00 end session
- amount  in  BAL_W  deposit/withdraw value
- another  in  1  1 = return to op select, 0 = end session
- out_valid  out  1  one-cycle result pulse
- atm_output  out  BAL_W  dispensed amount or balance
- status  out  3  result code
- busy  out  1  session active

Function
REQ-008 The FSM SHALL have states IDLE, PIN_WAIT, PIN_CHECK, OP_WAIT, EXEC, RESULT, ANOTHER.
REQ-009 IDLE->PIN_WAIT when card_inserted=1; card_id SHALL be latched in that cycle.
REQ-010 PIN_WAIT->PIN_CHECK on pin_valid; pin_in SHALL be latched.
REQ-011 PIN_CHECK SHALL take one cycle.
- Match with the account unlocked: clear its fail counter and go to OP_WAIT.
- Mismatch: increment the fail counter, give status BAD_PIN, and return to PIN_WAIT.
- When the counter reaches MAX_TRIES: set the lock bit, give status LOCKED, and go to IDLE.
- Locked account: status LOCKED, go to IDLE.
REQ-012 OP_WAIT->EXEC on op_valid with op_sel≠00; op_sel=00 SHALL go to IDLE with status OK and an out_valid pulse.
REQ-013 Deposit: balance += amount, saturating at 2^BAL_W-1; saturation SHALL give status OVERFLOW with the balance held at maximum.
REQ-014 Withdraw rules:
- amount > balance: status INSUFFICIENT, no change.
- Session total + amount > SESSION_LIMIT: status LIMIT, no change.
- Otherwise: subtract amount, add it to the session total, atm_output=amount, status OK.
REQ-015 Balance op: atm_output = current balance, status OK.
REQ-016 EXEC->RESULT SHALL take exactly one cycle. RESULT SHALL assert out_valid for one cycle, so the result appears 2 cycles after the op_valid cycle.
REQ-017 atm_output and status SHALL hold until the next out_valid; atm_output SHALL be 0 for non-dispensing results.
REQ-018 ANOTHER: another=1 -> OP_WAIT; another=0 -> IDLE.
REQ-019 card_inserted=0 in any non-IDLE state SHALL force IDLE next cycle, abort any uncommitted op, and zero the session total. A balance update in EXEC SHALL still commit.
REQ-020 pin_valid and op_valid outside their wait states SHALL be ignored.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Status codes SHALL be: OK=0, BAD_PIN=1, LOCKED=2, INSUFFICIENT=3, LIMIT=4, OVERFLOW=5.

Reset
REQ-023 On rst the block SHALL return to IDLE and clear out_valid, atm_output, status, busy, the session total, all fail counters and all lock bits.
REQ-024 On rst PINs SHALL load 1000+i and balances SHALL load INIT_BAL[i] from the package; rst overrides every other input.

Configuration
REQ-025 With ATM_SESSION_LIMIT_EN defined, REQ-014's SESSION_LIMIT check SHALL apply. Without it, the check, the session total register and the LIMIT code SHALL be absent; withdraw is bounded by balance only.

Structure
REQ-026 Package atm_pkg SHALL hold the state enum, status enum, op_sel constants and the INIT_BAL table.
REQ-027 Account storage (PIN, balance, fail counter, lock bit per slot; one read port; one write port) SHALL be in sub-module atm_account_bank.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Account 2, PIN 1002, deposit 500, then balance -> out_valid with atm_output=550 and status OK.
- Account 2, PIN 1002, withdraw 100 -> status INSUFFICIENT, atm_output=0, balance stays 50.
- Account 0, three PINs of 1234 -> BAD_PIN, BAD_PIN, LOCKED; then correct PIN 1000 on reinsertion -> LOCKED.
- With ATM_SESSION_LIMIT_EN, account 1: withdraw 600 (OK) then withdraw 500 -> LIMIT, balance stays 19400.
- Account 1, deposit 65535 -> OVERFLOW, balance 65535.
- Card removed in OP_WAIT -> IDLE next cycle, busy=0; rst mid-session -> all outputs 0 and balances reloaded.

Source files
------------

// File: rtl/atm_pkg.sv
// atm_pkg -- shared types and constants for the ATM controller.
//   state_e    : controller FSM states
//   status_e   : result codes driven on atm_controller.status
//   OP_*       : op_sel encodings
//   INIT_BAL   : per-slot balance loaded on reset (truncated to BAL_W)
// Build option: ATM_SESSION_LIMIT_EN adds the LIMIT result code.
package atm_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PIN_WAIT  = 3'd1,
        S_PIN_CHECK = 3'd2,
        S_OP_WAIT   = 3'd3,
        S_EXEC      = 3'd4,
        S_RESULT    = 3'd5,
        S_ANOTHER   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ST_OK           = 3'd0,
        ST_BAD_PIN      = 3'd1,
        ST_LOCKED       = 3'd2,
        ST_INSUFFICIENT = 3'd3,
`ifdef ATM_SESSION_LIMIT_EN
        ST_LIMIT        = 3'd4,
`endif
        ST_OVERFLOW     = 3'd5
    } status_e;

    localparam logic [1:0] OP_END      = 2'b00;
    localparam logic [1:0] OP_WITHDRAW = 2'b01;
    localparam logic [1:0] OP_DEPOSIT  = 2'b10;
    localparam logic [1:0] OP_BALANCE  = 2'b11;

    // Covers the largest supported bank (64 slots).
    localparam logic [31:0] INIT_BAL [64] = '{
        0: 32'd1000,  1: 32'd20000, 2: 32'd50,    3: 32'd300,
        4: 32'd5000,  5: 32'd0,     6: 32'd65000, 7: 32'd12345,
        default: 32'd100
    };

endpackage

// File: rtl/atm_account_bank.sv
// atm_account_bank -- per-slot account storage.
//   One combinational read port (rd_addr -> pin/bal/fail/lock) and one
//   synchronous write port updating bal/fail/lock of slot wr_addr.
//   PINs are fixed after reset (1000 + slot index).
//   clk, rst : clock, synchronous active-high reset (reloads every slot)
module atm_account_bank
    import atm_pkg::*;
#(
    parameter int NUM_ACCOUNTS = 8,
    parameter int BAL_W        = 16,
    parameter int PIN_W        = 16,
    parameter int FAIL_W       = 2,
    parameter int AW           = $clog2(NUM_ACCOUNTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     rd_addr,
    output logic [PIN_W-1:0]  rd_pin,
    output logic [BAL_W-1:0]  rd_bal,
    output logic [FAIL_W-1:0] rd_fail,
    output logic              rd_lock,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [BAL_W-1:0]  wr_bal,
    input  logic [FAIL_W-1:0] wr_fail,
    input  logic              wr_lock
);

    logic [NUM_ACCOUNTS-1:0][PIN_W-1:0]  pin;
    logic [NUM_ACCOUNTS-1:0][BAL_W-1:0]  bal;
    logic [NUM_ACCOUNTS-1:0][FAIL_W-1:0] fail;
    logic [NUM_ACCOUNTS-1:0]             lock;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                pin[i]  <= PIN_W'(1000 + i);
                bal[i]  <= BAL_W'(INIT_BAL[i]);
                fail[i] <= '0;
                lock[i] <= 1'b0;
            end
        end else if (wr_en) begin
            bal[wr_addr]  <= wr_bal;
            fail[wr_addr] <= wr_fail;
            lock[wr_addr] <= wr_lock;
        end
    end

    assign rd_pin  = pin[rd_addr];
    assign rd_bal  = bal[rd_addr];
    assign rd_fail = fail[rd_addr];
    assign rd_lock = lock[rd_addr];

endmodule

// File: rtl/atm_controller.sv
// atm_controller -- card session FSM: PIN check with lockout, then
// withdraw / deposit / balance operations against atm_account_bank.
//   card_inserted/card_id : card presence level and slot index
//   pin_valid/pin_in      : PIN strobe and value
//   op_valid/op_sel/amount: operation strobe, code, value
//   another               : 1 = next op, 0 = end session (sampled after result)
//   out_valid/atm_output/status : one-cycle result pulse, held data/code
//   busy                  : session active (FSM not idle)
// Build option: ATM_SESSION_LIMIT_EN enables the per-session withdraw cap.
module atm_controller
    import atm_pkg::*;
#(
    parameter int NUM_ACCOUNTS  = 8,
    parameter int BAL_W         = 16,
    parameter int PIN_W         = 16,
    parameter int MAX_TRIES     = 3,
    parameter int SESSION_LIMIT = 1000,
    parameter int AW            = $clog2(NUM_ACCOUNTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             card_inserted,
    input  logic [AW-1:0]    card_id,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin_in,
    input  logic             op_valid,
    input  logic [1:0]       op_sel,
    input  logic [BAL_W-1:0] amount,
    input  logic             another,
    output logic             out_valid,
    output logic [BAL_W-1:0] atm_output,
    output logic [2:0]       status,
    output logic             busy
);

    localparam int FAIL_W = $clog2(MAX_TRIES + 1);

    state_e             state;
    logic [AW-1:0]      acct;
    logic [PIN_W-1:0]   pin_q;
    logic [1:0]         op_q;
    logic [BAL_W-1:0]   amt_q;

    logic [PIN_W-1:0]   rd_pin;
    logic [BAL_W-1:0]   rd_bal;
    logic [FAIL_W-1:0]  rd_fail;
    logic               rd_lock;
    logic               wr_en;
    logic [BAL_W-1:0]   wr_bal;
    logic [FAIL_W-1:0]  wr_fail;
    logic               wr_lock;

    // Bank writes are registered: the slot updates one cycle after
    // PIN_CHECK/EXEC, which always lands before that slot is read again.
    atm_account_bank #(
        .NUM_ACCOUNTS (NUM_ACCOUNTS),
        .BAL_W        (BAL_W),
        .PIN_W        (PIN_W),
        .FAIL_W       (FAIL_W),
        .AW           (AW)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (acct),
        .rd_pin  (rd_pin),
        .rd_bal  (rd_bal),
        .rd_fail (rd_fail),
        .rd_lock (rd_lock),
        .wr_en   (wr_en),
        .wr_addr (acct),
        .wr_bal  (wr_bal),
        .wr_fail (wr_fail),
        .wr_lock (wr_lock)
    );

    logic [FAIL_W-1:0] fail_inc;
    logic [BAL_W:0]    dep_sum;
    assign fail_inc = rd_fail + 1'b1;
    assign dep_sum  = {1'b0, rd_bal} + {1'b0, amt_q};

`ifdef ATM_SESSION_LIMIT_EN
    logic [BAL_W-1:0] sess;
    logic [BAL_W:0]   sess_sum;
    logic [BAL_W-1:0] exec_add;
    assign sess_sum = {1'b0, sess} + {1'b0, amt_q};
`endif

    // EXEC outcome, evaluated against the selected slot.
    logic             exec_wr;
    logic [BAL_W-1:0] exec_bal;
    logic [BAL_W-1:0] exec_out;
    status_e          exec_st;

    always_comb begin
        exec_wr  = 1'b0;
        exec_bal = rd_bal;
        exec_out = '0;
        exec_st  = ST_OK;
`ifdef ATM_SESSION_LIMIT_EN
        exec_add = '0;
`endif
        case (op_q)
            OP_DEPOSIT: begin
                exec_wr = 1'b1;
                if (dep_sum[BAL_W]) begin
                    exec_bal = '1;
                    exec_st  = ST_OVERFLOW;
                end else begin
                    exec_bal = dep_sum[BAL_W-1:0];
                end
            end
            OP_WITHDRAW: begin
                if (amt_q > rd_bal) begin
                    exec_st = ST_INSUFFICIENT;
`ifdef ATM_SESSION_LIMIT_EN
                end else if (sess_sum > (BAL_W+1)'(SESSION_LIMIT)) begin
                    exec_st = ST_LIMIT;
`endif
                end else begin
                    exec_wr  = 1'b1;
                    exec_bal = rd_bal - amt_q;
                    exec_out = amt_q;
`ifdef ATM_SESSION_LIMIT_EN
                    exec_add = amt_q;
`endif
                end
            end
            OP_BALANCE: exec_out = rd_bal;
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            acct       <= '0;
            pin_q      <= '0;
            op_q       <= '0;
            amt_q      <= '0;
            out_valid  <= 1'b0;
            atm_output <= '0;
            status     <= ST_OK;
            wr_en      <= 1'b0;
            wr_bal     <= '0;
            wr_fail    <= '0;
            wr_lock    <= 1'b0;
`ifdef ATM_SESSION_LIMIT_EN
            sess       <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            wr_en     <= 1'b0;
            // Card pulled: abort. EXEC handles it itself so its write commits.
            if (state != S_IDLE && state != S_EXEC && !card_inserted) begin
                state <= S_IDLE;
`ifdef ATM_SESSION_LIMIT_EN
                sess  <= '0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
`ifdef ATM_SESSION_LIMIT_EN
                        sess <= '0;
`endif
                        if (card_inserted) begin
                            acct  <= card_id;
                            state <= S_PIN_WAIT;
                        end
                    end
                    S_PIN_WAIT: if (pin_valid) begin
                        pin_q <= pin_in;
                        state <= S_PIN_CHECK;
                    end
                    S_PIN_CHECK: begin
                        wr_bal <= rd_bal;
                        if (rd_lock) begin
                            out_valid  <= 1'b1;
                            atm_output <= '0;
                            status     <= ST_LOCKED;
                            state      <= S_IDLE;
                        end else if (pin_q == rd_pin) begin
                            wr_en   <= 1'b1;
                            wr_fail <= '0;
                            wr_lock <= 1'b0;
                            state   <= S_OP_WAIT;
                        end else begin
                            wr_en      <= 1'b1;
                            wr_fail    <= fail_inc;
                            out_valid  <= 1'b1;
                            atm_output <= '0;
                            if (fail_inc >= FAIL_W'(MAX_TRIES)) begin
                                wr_lock <= 1'b1;
                                status  <= ST_LOCKED;
                                state   <= S_IDLE;
                            end else begin
                                wr_lock <= 1'b0;
                                status  <= ST_BAD_PIN;
                                state   <= S_PIN_WAIT;
                            end
                        end
                    end
                    S_OP_WAIT: if (op_valid) begin
                        if (op_sel == OP_END) begin
                            out_valid  <= 1'b1;
                            atm_output <= '0;
                            status     <= ST_OK;
                            state      <= S_IDLE;
                        end else begin
                            op_q  <= op_sel;
                            amt_q <= amount;
                            state <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        wr_en   <= exec_wr;
                        wr_bal  <= exec_bal;
                        wr_fail <= rd_fail;
                        wr_lock <= rd_lock;
                        if (card_inserted) begin
                            out_valid  <= 1'b1;
                            atm_output <= exec_out;
                            status     <= exec_st;
                            state      <= S_RESULT;
`ifdef ATM_SESSION_LIMIT_EN
                            sess       <= sess + exec_add;
`endif
                        end else begin
                            state <= S_IDLE;
`ifdef ATM_SESSION_LIMIT_EN
                            sess  <= '0;
`endif
                        end
                    end
                    S_RESULT:  state <= S_ANOTHER;
                    S_ANOTHER: state <= another ? S_OP_WAIT : S_IDLE;
                    default:   state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_atm_controller.sv
module tb_atm_controller;
    import atm_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        card_inserted;
    logic [2:0]  card_id;
    logic        pin_valid;
    logic [15:0] pin_in;
    logic        op_valid;
    logic [1:0]  op_sel;
    logic [15:0] amount;
    logic        another;
    logic        out_valid;
    logic [15:0] atm_output;
    logic [2:0]  status;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    atm_controller dut (
        .clk           (clk),
        .rst           (rst),
        .card_inserted (card_inserted),
        .card_id       (card_id),
        .pin_valid     (pin_valid),
        .pin_in        (pin_in),
        .op_valid      (op_valid),
        .op_sel        (op_sel),
        .amount        (amount),
        .another       (another),
        .out_valid     (out_valid),
        .atm_output    (atm_output),
        .status        (status),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input int id);
        card_inserted = 1'b1;
        card_id       = 3'(id);
        tick();
    endtask

    // Leaves the bench one cycle after PIN_CHECK, where any pulse shows.
    task automatic enter_pin(input int p);
        pin_valid = 1'b1;
        pin_in    = 16'(p);
        tick();
        pin_valid = 1'b0;
        tick();
    endtask

    // Op in OP_WAIT; checks the result pulse 2 cycles later, then settles.
    task automatic do_op(input string tag, input logic [1:0] sel, input int amt,
                         input int exp_out, input int exp_st);
        op_valid = 1'b1;
        op_sel   = sel;
        amount   = 16'(amt);
        another  = 1'b1;
        tick();
        op_valid = 1'b0;
        chk({tag, ".early"}, int'(out_valid), 0);
        tick();
        chk({tag, ".vld"}, int'(out_valid), 1);
        chk({tag, ".out"}, int'(atm_output), exp_out);
        chk({tag, ".st"},  int'(status), exp_st);
        tick();
        tick();
    endtask

    task automatic pull_card();
        card_inserted = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; card_inserted = 1'b0; card_id = '0; pin_valid = 1'b0;
        pin_in = '0; op_valid = 1'b0; op_sel = '0; amount = '0; another = 1'b0;
        repeat (3) tick();
        chk("rst.vld",  int'(out_valid), 0);
        chk("rst.out",  int'(atm_output), 0);
        chk("rst.st",   int'(status), 0);
        chk("rst.busy", int'(busy), 0);
        rst = 1'b0;
        tick();

        // Account 2 (balance 50)
        insert(2);
        chk("a2.busy", int'(busy), 1);
        enter_pin(1002);
        chk("a2.pinok", int'(out_valid), 0);
        do_op("a2.wd100", OP_WITHDRAW, 100, 0, 3);
        do_op("a2.bal50", OP_BALANCE, 0, 50, 0);
        do_op("a2.dep500", OP_DEPOSIT, 500, 0, 0);
        do_op("a2.bal550", OP_BALANCE, 0, 550, 0);
        chk("a2.hold", int'(atm_output), 550);
        op_valid = 1'b1; op_sel = OP_END;
        tick();
        op_valid = 1'b0; card_inserted = 1'b0;
        chk("end.vld",  int'(out_valid), 1);
        chk("end.st",   int'(status), 0);
        chk("end.out",  int'(atm_output), 0);
        chk("end.busy", int'(busy), 0);
        tick();
        chk("end.pulse1", int'(out_valid), 0);

        // Account 0 lockout
        insert(0);
        enter_pin(1234);
        chk("lk1.vld", int'(out_valid), 1);
        chk("lk1.st",  int'(status), 1);
        chk("lk1.busy", int'(busy), 1);
        enter_pin(1234);
        chk("lk2.st",  int'(status), 1);
        enter_pin(1234);
        chk("lk3.st",  int'(status), 2);
        chk("lk3.busy", int'(busy), 0);
        pull_card();
        insert(0);
        enter_pin(1000);
        chk("lk4.vld", int'(out_valid), 1);
        chk("lk4.st",  int'(status), 2);
        chk("lk4.busy", int'(busy), 0);
        pull_card();

        // Account 1 (balance 20000)
        insert(1);
        enter_pin(1001);
        do_op("a1.wd600", OP_WITHDRAW, 600, 600, 0);
`ifdef ATM_SESSION_LIMIT_EN
        do_op("a1.wd500", OP_WITHDRAW, 500, 0, 4);
        do_op("a1.bal", OP_BALANCE, 0, 19400, 0);
`else
        do_op("a1.wd500", OP_WITHDRAW, 500, 500, 0);
        do_op("a1.bal", OP_BALANCE, 0, 18900, 0);
`endif
        do_op("a1.ovf", OP_DEPOSIT, 65535, 0, 5);
        do_op("a1.balmax", OP_BALANCE, 0, 65535, 0);
        // Card removed in OP_WAIT
        pull_card();
        chk("rm.busy", int'(busy), 0);
        chk("rm.vld",  int'(out_valid), 0);

        // Reset mid-session
        insert(2);
        enter_pin(1002);
        do_op("a2.dep100", OP_DEPOSIT, 100, 0, 0);
        rst = 1'b1; card_inserted = 1'b0;
        tick();
        chk("mrst.vld",  int'(out_valid), 0);
        chk("mrst.out",  int'(atm_output), 0);
        chk("mrst.st",   int'(status), 0);
        chk("mrst.busy", int'(busy), 0);
        rst = 1'b0;
        tick();
        insert(2);
        enter_pin(1002);
        do_op("mrst.bal2", OP_BALANCE, 0, 50, 0);
        pull_card();
        insert(0);
        enter_pin(1000);
        chk("unlk.vld",  int'(out_valid), 0);
        chk("unlk.busy", int'(busy), 1);
        // PIN strobe outside PIN_WAIT is ignored
        pin_valid = 1'b1; pin_in = 16'd1234;
        tick();
        pin_valid = 1'b0;
        tick();
        chk("ign.vld",  int'(out_valid), 0);
        do_op("unlk.bal", OP_BALANCE, 0, 1000, 0);
        pull_card();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
